// File: rtl/vector_lane_alu.sv
// Single-lane element ALU of the vector function unit: one element per cycle,
// registered 64-bit element result or 1-bit mask result in bit 0.
module vector_lane_alu #(
    parameter int LANE_INDEX  = 0,
    parameter int LEN         = 32,
    parameter int LONGEST_LEN = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             PREV_VSEW,
    input  logic [2:0]             CUR_VSEW,
    input  logic                   vm,
    input  logic [LONGEST_LEN-1:0] vs1,
    input  logic [LONGEST_LEN-1:0] vs2,
    input  logic [LONGEST_LEN-1:0] vs3,
    input  logic                   mask,
    input  logic [LEN-1:0]         imm,
    input  logic [LEN-1:0]         rs,
    input  logic [2:0]             alu_signal,
    input  logic [1:0]             vec_operand_type,
    input  logic                   is_mask_operation,
    input  logic [5:0]             opcode,
    output logic [LONGEST_LEN-1:0] result
);

    if (LANE_INDEX < 0 || LEN > LONGEST_LEN || LONGEST_LEN != 64) begin : g_param_chk
        $error("vector_lane_alu: unsupported parameterisation");
    end

    function automatic logic [63:0] sew_mask(input logic [2:0] vsew);
        case (vsew)
            3'd0:    sew_mask = 64'h0000_0000_0000_00FF;
            3'd1:    sew_mask = 64'h0000_0000_0000_FFFF;
            3'd2:    sew_mask = 64'h0000_0000_FFFF_FFFF;
            default: sew_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] sext_sew(input logic [63:0] x, input logic [2:0] vsew);
        case (vsew)
            3'd0:    sext_sew = {{56{x[7]}}, x[7:0]};
            3'd1:    sext_sew = {{48{x[15]}}, x[15:0]};
            3'd2:    sext_sew = {{32{x[31]}}, x[31:0]};
            default: sext_sew = x;
        endcase
    endfunction

    // Bit just above the SEW field: carry of a sum, or borrow of a difference.
    function automatic logic carry_bit(input logic [64:0] s, input logic [2:0] vsew);
        case (vsew)
            3'd0:    carry_bit = s[8];
            3'd1:    carry_bit = s[16];
            3'd2:    carry_bit = s[32];
            default: carry_bit = s[64];
        endcase
    endfunction

    logic [63:0] w_pmask, w_cmask, w_a_raw, w_a, w_b, w_c;
    logic [63:0] w_raw, w_full, w_next;
    logic [64:0] w_sum65, w_dif65;
    logic        w_cin, w_carry_op, w_active;
    logic [63:0] r_result;

    // Operand selection, operation decode, masking and output formatting.
    always_comb begin
        w_pmask = sew_mask(PREV_VSEW);
        w_cmask = sew_mask(CUR_VSEW);
        case (vec_operand_type)
            2'd1:    w_a_raw = {{(64-LEN){rs[LEN-1]}}, rs};
            2'd2:    w_a_raw = {{(64-LEN){imm[LEN-1]}}, imm};
            default: w_a_raw = vs1;
        endcase
        w_a     = w_a_raw & w_pmask;
        w_b     = vs2 & w_pmask;
        w_c     = vs3 & w_pmask;
        w_cin   = vm ? 1'b0 : mask;
        w_sum65 = {1'b0, w_b} + {1'b0, w_a} + {64'd0, w_cin};
        w_dif65 = {1'b0, w_b} - {1'b0, w_a} - {64'd0, w_cin};
        case (opcode)
            6'd0:                w_raw = w_b + w_a;
            6'd1:                w_raw = w_b - w_a;
            6'd2:                w_raw = w_b + w_a;
            6'd3:                w_raw = w_b - w_a;
            6'd4:                w_raw = sext_sew(w_b, PREV_VSEW) + sext_sew(w_a, PREV_VSEW);
            6'd5:                w_raw = sext_sew(w_b, PREV_VSEW) - sext_sew(w_a, PREV_VSEW);
            6'd6:                w_raw = w_b + w_a + {63'd0, mask};
            6'd7:                w_raw = w_b - w_a - {63'd0, mask};
            6'd8:                w_raw = {63'd0, carry_bit(w_sum65, PREV_VSEW)};
            6'd9:                w_raw = {63'd0, carry_bit(w_dif65, PREV_VSEW)};
            6'd10:               w_raw = (w_a * w_b) + w_c;
            6'd11:               w_raw = w_c - (w_a * w_b);
            6'd12:               w_raw = (w_a * w_c) + w_b;
            6'd13, 6'd14, 6'd15: w_raw = w_b;
            6'd16, 6'd17, 6'd18: w_raw = sext_sew(w_b, PREV_VSEW);
            default:             w_raw = 64'd0;
        endcase
        // Carry-chain ops consume the mask bit themselves and are never masked off.
        w_carry_op = (opcode >= 6'd6) && (opcode <= 6'd9);
        w_active   = vm | mask | w_carry_op;
        if (w_active) begin
            w_full = w_raw;
        end else begin
            w_full = vs3;
        end
        if (is_mask_operation) begin
            w_next = {63'd0, w_full[0]};
        end else begin
            w_next = w_full & w_cmask;
        end
    end

    // Result register: cleared asynchronously, loaded only on compute cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 64'd0;
        end else if (alu_signal != 3'd0) begin
            r_result <= w_next;
        end else begin
            r_result <= r_result;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_vector_lane_alu.sv
// Table-driven self-checking bench for vector_lane_alu with a latency-1 scoreboard queue.
module tb_vector_lane_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  PREV_VSEW, CUR_VSEW;
    logic        vm, mask, is_mask_operation;
    logic [63:0] vs1, vs2, vs3;
    logic [31:0] imm, rs;
    logic [2:0]  alu_signal;
    logic [1:0]  vec_operand_type;
    logic [5:0]  opcode;
    logic [63:0] result;

    vector_lane_alu #(.LANE_INDEX(0), .LEN(32), .LONGEST_LEN(64)) dut (
        .clk(clk), .rst(rst), .PREV_VSEW(PREV_VSEW), .CUR_VSEW(CUR_VSEW), .vm(vm),
        .vs1(vs1), .vs2(vs2), .vs3(vs3), .mask(mask), .imm(imm), .rs(rs),
        .alu_signal(alu_signal), .vec_operand_type(vec_operand_type),
        .is_mask_operation(is_mask_operation), .opcode(opcode), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  prev, cur;
        logic [1:0]  opt;
        logic [5:0]  op;
        logic        vm, mask, ism;
        logic [63:0] vs1, vs2, vs3;
        logic [31:0] rs, imm;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic add_vec(input logic [2:0] prev, input logic [2:0] cur, input logic [1:0] opt,
                           input logic [5:0] op, input logic v_m, input logic m,
                           input logic ism, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [31:0] r, input logic [31:0] im,
                           input logic [63:0] e);
        vec_t v;
        v.prev = prev; v.cur = cur; v.opt = opt; v.op = op; v.vm = v_m; v.mask = m;
        v.ism = ism; v.vs1 = a; v.vs2 = b; v.vs3 = c; v.rs = r; v.imm = im; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v, input logic [2:0] sig);
        PREV_VSEW = v.prev; CUR_VSEW = v.cur; vec_operand_type = v.opt; opcode = v.op;
        vm = v.vm; mask = v.mask; is_mask_operation = v.ism;
        vs1 = v.vs1; vs2 = v.vs2; vs3 = v.vs3; rs = v.rs; imm = v.imm;
        alu_signal = sig;
    endtask

    initial begin
        vec_t v;
        logic [63:0] held;
        //       prev  cur   opt   op     vm    mask  ism   vs1                    vs2                    vs3           rs            imm           expected
        add_vec(3'd0, 3'd0, 2'd0, 6'd0,  1'b1, 1'b0, 1'b0, 64'h20,               64'hF0,                64'h0,        32'h0,        32'h0,        64'h10);
        add_vec(3'd0, 3'd0, 2'd1, 6'd0,  1'b1, 1'b0, 1'b0, 64'h20,               64'hF0,                64'h0,        32'hFFFFFFFF, 32'h0,        64'hEF);
        add_vec(3'd2, 3'd2, 2'd0, 6'd1,  1'b0, 1'b0, 1'b0, 64'h7,                64'h5,                 64'h1234,     32'h0,        32'h0,        64'h1234);
        add_vec(3'd2, 3'd2, 2'd0, 6'd1,  1'b0, 1'b1, 1'b0, 64'h7,                64'h5,                 64'h1234,     32'h0,        32'h0,        64'hFFFFFFFE);
        add_vec(3'd0, 3'd0, 2'd0, 6'd8,  1'b1, 1'b0, 1'b1, 64'h01,               64'hFF,                64'h0,        32'h0,        32'h0,        64'h1);
        add_vec(3'd0, 3'd0, 2'd0, 6'd6,  1'b1, 1'b1, 1'b0, 64'h01,               64'hFF,                64'h0,        32'h0,        32'h0,        64'h01);
        add_vec(3'd0, 3'd1, 2'd0, 6'd4,  1'b1, 1'b0, 1'b0, 64'h80,               64'h80,                64'h0,        32'h0,        32'h0,        64'hFF00);
        add_vec(3'd0, 3'd2, 2'd0, 6'd17, 1'b1, 1'b0, 1'b0, 64'h0,                64'h80,                64'h0,        32'h0,        32'h0,        64'hFFFFFF80);
        add_vec(3'd0, 3'd2, 2'd0, 6'd14, 1'b1, 1'b0, 1'b0, 64'h0,                64'h80,                64'h0,        32'h0,        32'h0,        64'h80);
        add_vec(3'd1, 3'd1, 2'd0, 6'd10, 1'b1, 1'b0, 1'b0, 64'd3,                64'd4,                 64'd10,       32'h0,        32'h0,        64'd22);
        add_vec(3'd1, 3'd1, 2'd0, 6'd12, 1'b1, 1'b0, 1'b0, 64'd3,                64'd4,                 64'd10,       32'h0,        32'h0,        64'd34);
        add_vec(3'd1, 3'd1, 2'd0, 6'd11, 1'b1, 1'b0, 1'b0, 64'd3,                64'd4,                 64'd10,       32'h0,        32'h0,        64'hFFFE);
        add_vec(3'd0, 3'd0, 2'd0, 6'd9,  1'b1, 1'b0, 1'b1, 64'h01,               64'h00,                64'h0,        32'h0,        32'h0,        64'h1);
        add_vec(3'd0, 3'd0, 2'd0, 6'd9,  1'b0, 1'b1, 1'b1, 64'h01,               64'h01,                64'h0,        32'h0,        32'h0,        64'h1);
        add_vec(3'd0, 3'd0, 2'd0, 6'd8,  1'b0, 1'b1, 1'b1, 64'h01,               64'hFE,                64'h0,        32'h0,        32'h0,        64'h1);
        add_vec(3'd0, 3'd0, 2'd0, 6'd8,  1'b1, 1'b1, 1'b1, 64'h01,               64'hFE,                64'h0,        32'h0,        32'h0,        64'h0);
        add_vec(3'd0, 3'd1, 2'd0, 6'd3,  1'b1, 1'b0, 1'b0, 64'h01,               64'h00,                64'h0,        32'h0,        32'h0,        64'hFFFF);
        add_vec(3'd0, 3'd1, 2'd0, 6'd2,  1'b1, 1'b0, 1'b0, 64'hFF,               64'hFF,                64'h0,        32'h0,        32'h0,        64'h1FE);
        add_vec(3'd0, 3'd3, 2'd0, 6'd18, 1'b1, 1'b0, 1'b0, 64'h0,                64'h80,                64'h0,        32'h0,        32'h0,        64'hFFFFFFFFFFFFFF80);
        add_vec(3'd0, 3'd0, 2'd0, 6'd20, 1'b1, 1'b0, 1'b0, 64'h3,                64'h4,                 64'h5,        32'h0,        32'h0,        64'h0);
        add_vec(3'd3, 3'd4, 2'd0, 6'd2,  1'b1, 1'b0, 1'b0, 64'h1,                64'hFFFFFFFFFFFFFFFF,  64'h0,        32'h0,        32'h0,        64'h0);
        add_vec(3'd3, 3'd3, 2'd2, 6'd1,  1'b1, 1'b0, 1'b0, 64'h0,                64'h0,                 64'h0,        32'h0,        32'hFFFFFFFF, 64'h1);
        add_vec(3'd0, 3'd0, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 64'h1,                64'h1,                 64'h3,        32'h0,        32'h0,        64'h1);
        add_vec(3'd1, 3'd1, 2'd0, 6'd7,  1'b1, 1'b1, 1'b0, 64'h0,                64'h0,                 64'h0,        32'h0,        32'h0,        64'hFFFF);
        add_vec(3'd3, 3'd3, 2'd3, 6'd0,  1'b1, 1'b0, 1'b0, 64'h2,                64'hFFFFFFFFFFFFFFFF,  64'h0,        32'h0,        32'h0,        64'h1);
        add_vec(3'd1, 3'd2, 2'd0, 6'd5,  1'b1, 1'b0, 1'b0, 64'h2,                64'h1,                 64'h0,        32'h0,        32'h0,        64'hFFFFFFFF);
        add_vec(3'd2, 3'd3, 2'd0, 6'd13, 1'b1, 1'b0, 1'b0, 64'h0,                64'hFFFFFFFF,          64'h0,        32'h0,        32'h0,        64'hFFFFFFFF);
        add_vec(3'd0, 3'd0, 2'd0, 6'd6,  1'b0, 1'b0, 1'b0, 64'h3,                64'h5,                 64'hAA,       32'h0,        32'h0,        64'h8);

        // Reset state and idle hold after release.
        v = vecs[0];
        drive(v, 3'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_value", result, 64'h0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("idle_after_reset", result, 64'h0);

        // Back-to-back vectors, one per cycle, varying the nonzero alu_signal code.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i], 3'((i % 7) + 1));
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard_empty at vec %0d", i);
            end else begin
                check($sformatf("vec[%0d] op=%0d", i, vecs[i].op), result, exp_q.pop_front());
            end
        end
        held = vecs[vecs.size()-1].exp;

        // alu_signal idle: result holds while other inputs change.
        @(negedge clk);
        drive(vecs[0], 3'd0);
        repeat (3) @(posedge clk);
        #1 check("hold_idle", result, held);

        // Asynchronous reset mid-operation, well away from any rising edge.
        @(negedge clk);
        drive(vecs[9], 3'd1);
        @(posedge clk);
        #1 check("pre_reset_macc", result, 64'd22);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("async_reset", result, 64'h0);
        @(negedge clk) rst = 1'b0;
        drive(vecs[10], 3'd0);
        @(posedge clk);
        #1 check("idle_after_midop_reset", result, 64'h0);

        // First compute after reset release yields a normal result.
        @(negedge clk);
        drive(vecs[10], 3'd4);
        @(posedge clk);
        #1 check("first_after_reset", result, 64'd34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vector_lane_alu.md
Name: vector_lane_alu

Overview:
- Single-lane element ALU of the vector function unit. One instance per lane; each computes one vector element per cycle.
- Takes one element of each vector source (zero-extended into 64 bits) plus the scalar/immediate operands.
- Produces a registered 64-bit element result, or a 1-bit mask result in bit 0.
- The dispatcher slices vector registers into lanes; the recaller packs lane results using CUR_VSEW.

Parameters:
- LANE_INDEX, 0, lane number; identification only, no functional effect.
- LEN, 32, scalar/immediate width.
- LONGEST_LEN, 64, element datapath width (max SEW).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- PREV_VSEW  input  3  source element width: 0=8b, 1=16b, 2=32b, 3=64b.
- CUR_VSEW  input  3  result element width, same encoding. Equals PREV_VSEW except for widening/extension ops.
- vm  input  1  1 = unmasked; 0 = masked by `mask`.
- vs1  input  64  element of vs1, zero-extended from PREV_VSEW.
- vs2  input  64  element of vs2, zero-extended.
- vs3  input  64  element of vd/vs3 (accumulator / old destination), zero-extended.
- mask  input  1  this element's mask bit (v0).
- imm  input  32  immediate, already sign-extended to 32 bits.
- rs  input  32  scalar register operand.
- alu_signal  input  3  0 = idle (result holds); any nonzero value = compute this cycle.
- vec_operand_type  input  2  operand A source: 0=OPIVV (vs1), 1=OPIVX (rs), 2=OPIVI (imm), 3=OPMVV (vs1).
- is_mask_operation  input  1  result is a 1-bit mask in bit 0.
- opcode  input  6  operation code (see Behaviour).
- result  output  64  registered element result.

Behaviour:
- Reset: result = 0 immediately (asynchronous).
- Latency: 1 cycle. Inputs sampled on the posedge where alu_signal != 0 appear on result after that edge. With alu_signal == 0, result holds.
- Operand A: vs1, rs or imm per vec_operand_type. rs/imm are sign-extended from 32 to 64 bits, then truncated to SEW. B = vs2, C = vs3, each interpreted at PREV_VSEW. All arithmetic is modulo 2^SEW.
- Opcodes:
  - 0 ADD: B+A.
  - 1 SUB: B-A.
  - 2 WADDU: zext(B)+zext(A) at 2*SEW.
  - 3 WSUBU: zext(B)-zext(A) at 2*SEW.
  - 4 WADD: sext(B)+sext(A) at 2*SEW.
  - 5 WSUB: sext(B)-sext(A) at 2*SEW.
  - 6 ADC: B+A+mask.
  - 7 SBC: B-A-mask.
  - 8 MADC: carry-out of B+A(+mask if vm=0), in bit 0.
  - 9 MSBC: borrow-out of B-A(-mask if vm=0), in bit 0.
  - 10 MACC: A*B+C.
  - 11 NMSAC: C-A*B.
  - 12 MADD: A*C+B.
  - 13/14/15 ZEXT2/4/8: zext(B) from PREV_VSEW to CUR_VSEW.
  - 16/17/18 SEXT2/4/8: sext(B) from PREV_VSEW to CUR_VSEW.
  - Any other opcode: result 0.
- Widening ops: source interpreted at PREV_VSEW, result width = CUR_VSEW (must equal 2*PREV_VSEW). If CUR_VSEW exceeds 64 bits, the result is truncated to 64.
- Output formatting: the result is truncated to CUR_VSEW and the upper bits are zero. When is_mask_operation=1, only bit 0 is meaningful; bits 63:1 = 0.
- Masking: for opcodes other than ADC/SBC/MADC/MSBC, vm=0 with mask=0 gives result = vs3 truncated to CUR_VSEW (undisturbed). For a mask op masked off in this way, bit 0 = vs3[0]. ADC/SBC always use mask as the carry/borrow input, independent of vm.
- Multiplies keep the low SEW bits only (signedness irrelevant).
- If rst asserts mid-operation, result clears at once. The first compute after release produces a normal result.

Test Plan:
- Reset: assert rst with result nonzero → result = 0 without a clock edge. Release, alu_signal=0 → result stays 0.
- ADD wrap: PREV=CUR=0, opcode 0, VV, vs2=0xF0, vs1=0x20, vm=1 → result = 0x10 after one edge. Same inputs as VX with rs=0xFFFFFFFF → 0xEF.
- Masking: opcode 1, PREV=CUR=2, vs2=5, vs1=7, vm=0, mask=0, vs3=0x1234 → result 0x1234. With mask=1 → 0xFFFFFFFE.
- Carry ops: MADC, PREV=0, vs2=0xFF, vs1=0x01, vm=1, is_mask_operation=1 → result = 1. ADC with the same operands and mask=1 → 0x01.
- Widening/extension:
  - WADD, PREV=0, CUR=1, vs2=0x80, vs1=0x80 → 0xFF00.
  - SEXT4, PREV=0, CUR=2, vs2=0x80 → 0xFFFFFF80.
  - ZEXT4 on the same input → 0x00000080.
- MAC: MACC, PREV=CUR=1, vs1=3, vs2=4, vs3=10 → 22. MADD with the same values → 34. NMSAC → 0xFFFE (−2).
